// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StIfRd = 3'd1,
    StLsRd = 3'd2,
    StLsWr = 3'd3,
    StDone = 3'd4
  } state_e;

  typedef enum logic {
    GntIf = 1'b0,
    GntLs = 1'b1
  } grant_e;

  localparam logic [1:0] SzByte   = 2'b00;
  localparam logic [1:0] SzHalf   = 2'b01;
  localparam logic [1:0] SzWord   = 2'b10;
  localparam logic [1:0] IoRegion = 2'b11;

  // Illegal size code 2'b11 falls into the word case.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SzByte:  return 3'd1;
      SzHalf:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] region);
    return region == IoRegion;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM/IO port between instruction fetch and the load/store buffer,
// serialising each request into byte transactions.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_done,
  output logic [31:0]           ic_data,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [1:0]            ls_size,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata
);

  state_e                  state_q, state_d;
  grant_e                  gnt_q, gnt_d;
  grant_e                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              len_q, len_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    iss_q, iss_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             buf_q, buf_d;
  logic [31:0]             ic_data_q, ic_data_d;
  logic [31:0]             ls_rdata_q, ls_rdata_d;

  logic [2:0]              issue_idx;
  logic [ADDR_WIDTH-1:0]   cur_addr;

  assign ic_data  = ic_data_q;
  assign ls_rdata = ls_rdata_q;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    iss_d        = 1'b0;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    ic_data_d    = ic_data_q;
    ls_rdata_d   = ls_rdata_q;
    mem_a        = '0;
    mem_dout     = 8'h00;
    mem_wr       = 1'b0;
    ic_done      = 1'b0;
    ls_done      = 1'b0;
    // iss_q means addr+cnt was put on the bus last cycle, so its byte is on mem_din now.
    issue_idx    = iss_q ? cnt_q + 3'd1 : cnt_q;
    cur_addr     = addr_q + ADDR_WIDTH'(cnt_q);

    unique case (state_q)
      StIdle: begin
        if (rdy && !rollback && (ic_req || ls_req)) begin
          if (ls_req && (!ic_req || last_grant_q == GntIf)) begin
            gnt_d   = GntLs;
            addr_d  = ls_addr;
            len_d   = size_to_len(ls_size);
            wdata_d = ls_wdata;
            state_d = ls_wr ? StLsWr : StLsRd;
          end else begin
            gnt_d   = GntIf;
            addr_d  = ic_addr;
            len_d   = 3'd4;
            state_d = StIfRd;
          end
          last_grant_d = gnt_d;
          cnt_d        = 3'd0;
          buf_d        = 32'h0;
        end
      end

      StIfRd, StLsRd: begin
        if (issue_idx < len_q) begin
          mem_a = addr_q + ADDR_WIDTH'(issue_idx);
        end
        if (rollback) begin
          state_d = StIdle;
        end else if (rdy) begin
          if (iss_q) begin
            buf_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 == len_q) begin
              state_d = StDone;
              if (gnt_q == GntIf) begin
                ic_data_d = buf_d;
              end else begin
                ls_rdata_d = buf_d;
              end
            end
          end
          iss_d = (issue_idx < len_q);
        end
        // With rdy low iss_d stays 0, so an in-flight byte is dropped and re-issued later.
      end

      StLsWr: begin
        mem_a    = cur_addr;
        mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        if (rdy && !(is_io(cur_addr[17:16]) && io_buffer_full)) begin
          mem_wr = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q + 3'd1 == len_q) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        if (rdy) begin
          state_d = StIdle;
          if (gnt_q == GntIf) begin
            ic_done = 1'b1;
          end else begin
            ls_done = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_q        <= GntIf;
      last_grant_q <= GntIf;
      addr_q       <= '0;
      len_q        <= 3'd0;
      cnt_q        <= 3'd0;
      iss_q        <= 1'b0;
      wdata_q      <= 32'h0;
      buf_q        <= 32'h0;
      ic_data_q    <= 32'h0;
      ls_rdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      iss_q        <= iss_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      ic_data_q    <= ic_data_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

endmodule
